// File: rtl/out_fifo_mc.sv
`default_nettype none
// ============================================================================
// Module   : out_fifo_mc
// Brief    : Multi-channel output FIFO with optional 2:1 read gearbox, flush
//            and sticky overflow/underflow flags.
// Revision : 1.0
// ============================================================================
module out_fifo_mc #(
    parameter int NCH                = 10,
    parameter int W                  = 8,
    parameter int DEPTH              = 8,
    parameter int RATIO              = 2,
    parameter int ALMOST_EMPTY_VALUE = 1,
    parameter int ALMOST_FULL_VALUE  = 1,
    parameter bit OUTPUT_DISABLE     = 1'b0
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic                        WREN,
    input  logic [NCH*W-1:0]            D,
    input  logic                        RDEN,
    input  logic                        FLUSH,
    output logic [NCH*(W/RATIO)-1:0]    Q,
    output logic                        EMPTY,
    output logic                        FULL,
    output logic                        ALMOSTEMPTY,
    output logic                        ALMOSTFULL,
    output logic [$clog2(DEPTH):0]      COUNT,
    output logic                        WROVF,
    output logic                        RDUNF
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = W / RATIO;
    localparam int HW = W / 2;
    localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] C_PINC  = AW'(1);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0]   C_AE    = (AW+1)'(ALMOST_EMPTY_VALUE);
    localparam logic [AW:0]   C_AF    = (AW+1)'(DEPTH - ALMOST_FULL_VALUE);

    logic [NCH*W-1:0]  mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;
    logic              phase_q, phase_d;
    logic [NCH*OW-1:0] q_q, q_d;
    logic              wrovf_q, wrovf_d;
    logic              rdunf_q, rdunf_d;

    logic              wr_ok;
    logic              rd_ok;
    logic              pop;
    logic [NCH*W-1:0]  rd_word;
    logic [NCH*OW-1:0] rd_sel;

    assign EMPTY       = (count_q == '0);
    assign FULL        = (count_q == C_DEPTH);
    assign ALMOSTEMPTY = (count_q <= C_AE);
    assign ALMOSTFULL  = (count_q >= C_AF);
    assign COUNT       = count_q;
    assign Q           = q_q;
    assign WROVF       = wrovf_q;
    assign RDUNF       = rdunf_q;

    // FLUSH wins over both ports, so neither side is accepted in that cycle.
    assign wr_ok   = WREN && !FULL && !FLUSH;
    assign rd_ok   = RDEN && !EMPTY && !FLUSH;
    assign pop     = rd_ok && ((RATIO == 1) || phase_q);
    assign rd_word = mem_q[rptr_q];

    generate
        if (RATIO == 2) begin : g_gear
            for (genvar c = 0; c < NCH; c++) begin : g_ch
                assign rd_sel[c*OW +: OW] = phase_q ? rd_word[c*W+HW +: HW]
                                                    : rd_word[c*W +: HW];
            end
        end else begin : g_direct
            assign rd_sel = rd_word;
        end
    endgenerate

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        phase_d = phase_q;
        q_d     = q_q;
        wrovf_d = wrovf_q | (WREN && FULL && !FLUSH);
        rdunf_d = rdunf_q | (RDEN && EMPTY && !FLUSH);
        if (FLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            phase_d = 1'b0;
            q_d     = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + C_PINC;
            end
            if (rd_ok) begin
                q_d     = OUTPUT_DISABLE ? '0 : rd_sel;
                phase_d = (RATIO == 2) ? !phase_q : 1'b0;
            end
            if (pop) begin
                rptr_d = rptr_q + C_PINC;
            end
            case ({wr_ok, pop})
                2'b10:   count_d = count_q + C_ONE;
                2'b01:   count_d = count_q - C_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem_q[wptr_q] <= D;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            phase_q <= 1'b0;
            q_q     <= '0;
            wrovf_q <= 1'b0;
            rdunf_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            phase_q <= phase_d;
            q_q     <= q_d;
            wrovf_q <= wrovf_d;
            rdunf_q <= rdunf_d;
        end
    end

endmodule
`default_nettype wire
